lfsr_param: RTL and testbench

Parametrised linear-feedback shift register: the next generation of the team's fixed 4-bit seedable LFSR.
- Width, tap mask and feedback topology (Fibonacci or Galois) are generic.
- Adds a step enable, load-over-step priority, a nonzero reset seed, all-zero lock-up detection, and a period measurement relative to the last loaded seed.
- Used as a pseudo-random source and as a self-checking test-pattern generator.

---
 rtl/lfsr_pkg.sv | 17 +
 rtl/lfsr_if.sv | 38 +++
 rtl/lfsr_next.sv | 30 +++
 rtl/lfsr_param.sv | 87 ++++++++
 tb/tb_lfsr_param.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/lfsr_pkg.sv
// Shared constants for the parametrised LFSR: feedback topology codes and
// the width-4 defaults inherited from the original fixed 4-bit generator.
package lfsr_pkg;

    localparam int unsigned MODE_FIB = 0;
    localparam int unsigned MODE_GAL = 1;

    localparam int unsigned DEFAULT_WIDTH = 4;
    localparam logic [3:0]  DEFAULT_TAPS_W4 = 4'b0011;
    localparam logic [3:0]  DEFAULT_SEED_W4 = 4'b0001;

    // Saturating increment used by the period counter.
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] max);
        return (value >= max) ? max : value + 32'd1;
    endfunction

endpackage

// File: rtl/lfsr_if.sv
// Control and observation signals of the LFSR grouped as one bundle.
// The master drives load/seed/enable; the slave (the LFSR) drives the rest.
interface lfsr_if #(
    parameter int unsigned WIDTH = 4
) ();

    logic             load;
    logic [WIDTH-1:0] seed;
    logic             enable;
    logic [WIDTH-1:0] state;
    logic             bit_out;
    logic             lockup;
    logic             period_done;
    logic [WIDTH-1:0] period_len;

    modport master (
        output load,
        output seed,
        output enable,
        input  state,
        input  bit_out,
        input  lockup,
        input  period_done,
        input  period_len
    );

    modport slave (
        input  load,
        input  seed,
        input  enable,
        output state,
        output bit_out,
        output lockup,
        output period_done,
        output period_len
    );

endinterface

// File: rtl/lfsr_next.sv
// Purely combinational next-state function of the LFSR, Fibonacci or Galois
// topology selected by MODE.
module lfsr_next
    import lfsr_pkg::*;
#(
    parameter int unsigned      WIDTH = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] TAPS  = DEFAULT_TAPS_W4,
    parameter int unsigned      MODE  = MODE_FIB
) (
    input  logic [WIDTH-1:0] state,
    output logic [WIDTH-1:0] next
);

    if (MODE == MODE_GAL) begin : g_galois
        // Bit 0 shifts out into the MSB and is XORed into every tapped lower bit.
        always_comb begin
            next = '0;
            next[WIDTH-1] = state[0];
            for (int i = 0; i < int'(WIDTH) - 1; i++) begin
                next[i] = state[i+1] ^ (TAPS[i] & state[0]);
            end
        end
    end else begin : g_fibonacci
        logic fb;

        assign fb   = ^(TAPS & state);
        assign next = {fb, state[WIDTH-1:1]};
    end

endmodule

// File: rtl/lfsr_param.sv
// Parametrised seedable LFSR with step enable, lock-up flag and period measurement.
// Build option: LFSR_LOCKUP_GUARD_EN replaces a zero load seed with RESET_SEED.
module lfsr_param
    import lfsr_pkg::*;
#(
    parameter int unsigned      WIDTH      = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] TAPS       = DEFAULT_TAPS_W4,
    parameter int unsigned      MODE       = MODE_FIB,
    parameter logic [WIDTH-1:0] RESET_SEED = DEFAULT_SEED_W4
) (
    input  logic   clk,
    input  logic   reset,
    lfsr_if.slave  bus
);

    logic [WIDTH-1:0] state_q, state_d;
    logic [WIDTH-1:0] ref_q, ref_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] len_q, len_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] step_next;
    logic [WIDTH-1:0] load_val;
    logic [31:0]      count_inc;

    lfsr_next #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .MODE  (MODE)
    ) u_next (
        .state (state_q),
        .next  (step_next)
    );

`ifdef LFSR_LOCKUP_GUARD_EN
    // A zero seed would park the register in its all-zero fixed point.
    assign load_val = (bus.seed == '0) ? RESET_SEED : bus.seed;
`else
    assign load_val = bus.seed;
`endif

    assign count_inc = sat_inc(32'(count_q), 32'({WIDTH{1'b1}}));

    always_comb begin
        state_d = state_q;
        ref_d   = ref_q;
        count_d = count_q;
        len_d   = len_q;
        done_d  = 1'b0;
        if (bus.load) begin
            state_d = load_val;
            ref_d   = load_val;
            count_d = '0;
        end else if (bus.enable) begin
            state_d = step_next;
            if (step_next == ref_q) begin
                done_d  = 1'b1;
                len_d   = count_q + WIDTH'(1);
                count_d = '0;
            end else begin
                count_d = count_inc[WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RESET_SEED;
            ref_q   <= RESET_SEED;
            count_q <= '0;
            len_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ref_q   <= ref_d;
            count_q <= count_d;
            len_q   <= len_d;
            done_q  <= done_d;
        end
    end

    assign bus.state       = state_q;
    assign bus.bit_out     = state_q[0];
    assign bus.lockup      = (state_q == '0);
    assign bus.period_done = done_q;
    assign bus.period_len  = len_q;

endmodule

// File: tb/tb_lfsr_param.sv
// Self-checking bench for lfsr_param: a Fibonacci (TAPS 0011) and a Galois
// (TAPS 0001) instance run side by side against an arithmetic reference model.
module tb_lfsr_param;

    logic clk;
    logic reset;

    int n_checks = 0;
    int n_fail   = 0;

    lfsr_if #(.WIDTH(4)) if_fib ();
    lfsr_if #(.WIDTH(4)) if_gal ();

    lfsr_param #(
        .WIDTH      (4),
        .TAPS       (4'b0011),
        .MODE       (0),
        .RESET_SEED (4'b0001)
    ) u_fib (
        .clk   (clk),
        .reset (reset),
        .bus   (if_fib.slave)
    );

    lfsr_param #(
        .WIDTH      (4),
        .TAPS       (4'b0001),
        .MODE       (1),
        .RESET_SEED (4'b0001)
    ) u_gal (
        .clk   (clk),
        .reset (reset),
        .bus   (if_gal.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state, index 0 = Fibonacci instance, 1 = Galois instance.
    int m_st[2];
    int m_ref[2];
    int m_cnt[2];
    int m_len[2];
    int m_done[2];

    function automatic int mdl_next(input int k, input int s);
        int taps;
        taps = (k == 0) ? 3 : 1;
        if (k == 0) return (s / 2) + 8 * ($countones(s & taps) % 2);
        return (s / 2) ^ ((s % 2 == 1) ? (taps | 8) : 0);
    endfunction

    function automatic int mdl_load_val(input int s);
`ifdef LFSR_LOCKUP_GUARD_EN
        return (s == 0) ? 1 : s;
`else
        return s;
`endif
    endfunction

    task automatic mdl_reset();
        for (int k = 0; k < 2; k++) begin
            m_st[k] = 1; m_ref[k] = 1; m_cnt[k] = 0; m_len[k] = 0; m_done[k] = 0;
        end
    endtask

    task automatic mdl_step(input int k, input bit ld, input int sd, input bit en);
        int nx;
        m_done[k] = 0;
        if (ld) begin
            m_st[k] = mdl_load_val(sd); m_ref[k] = m_st[k]; m_cnt[k] = 0;
        end else if (en) begin
            nx = mdl_next(k, m_st[k]);
            m_st[k] = nx;
            if (nx == m_ref[k]) begin
                m_done[k] = 1; m_len[k] = (m_cnt[k] + 1) % 16; m_cnt[k] = 0;
            end else begin
                m_cnt[k] = (m_cnt[k] >= 15) ? 15 : m_cnt[k] + 1;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all();
        chk("fib_state",  32'(if_fib.state),       32'(m_st[0]));
        chk("fib_bit",    32'(if_fib.bit_out),     32'(m_st[0] % 2));
        chk("fib_lockup", 32'(if_fib.lockup),      32'(m_st[0] == 0));
        chk("fib_done",   32'(if_fib.period_done), 32'(m_done[0]));
        chk("fib_len",    32'(if_fib.period_len),  32'(m_len[0]));
        chk("gal_state",  32'(if_gal.state),       32'(m_st[1]));
        chk("gal_bit",    32'(if_gal.bit_out),     32'(m_st[1] % 2));
        chk("gal_lockup", 32'(if_gal.lockup),      32'(m_st[1] == 0));
        chk("gal_done",   32'(if_gal.period_done), 32'(m_done[1]));
        chk("gal_len",    32'(if_gal.period_len),  32'(m_len[1]));
    endtask

    task automatic cycle(input bit ld, input logic [3:0] sf, input logic [3:0] sg, input bit en);
        @(negedge clk);
        if_fib.load = ld; if_fib.seed = sf; if_fib.enable = en;
        if_gal.load = ld; if_gal.seed = sg; if_gal.enable = en;
        @(posedge clk);
        mdl_step(0, ld, int'(sf), en);
        mdl_step(1, ld, int'(sg), en);
        #1;
        chk_all();
    endtask

    logic [3:0] fib_exp [15];
    logic [3:0] gal_exp [5];
    int         frozen;

    initial begin
        fib_exp = '{4'h4, 4'h2, 4'h9, 4'hC, 4'h6, 4'hB, 4'h5, 4'hA,
                    4'hD, 4'hE, 4'hF, 4'h7, 4'h3, 4'h1, 4'h8};
        gal_exp = '{4'h9, 4'hD, 4'hF, 4'hE, 4'h7};

        // 1. Reset defaults
        reset = 1'b0;
        if_fib.load = 1'b0; if_fib.seed = '0; if_fib.enable = 1'b0;
        if_gal.load = 1'b0; if_gal.seed = '0; if_gal.enable = 1'b0;
        mdl_reset();
        #12;
        chk("rst_state",  32'(if_fib.state), 32'h1);
        chk("rst_len",    32'(if_fib.period_len), 32'h0);
        chk("rst_done",   32'(if_fib.period_done), 32'h0);
        chk("rst_lockup", 32'(if_fib.lockup), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        cycle(1'b0, 4'h0, 4'h0, 1'b0);
        chk("hold_state", 32'(if_fib.state), 32'h1);

        // 2/3. Full periods: Fibonacci from 1000, Galois from 0001
        cycle(1'b1, 4'h8, 4'h1, 1'b0);
        chk("load_fib", 32'(if_fib.state), 32'h8);
        for (int i = 0; i < 15; i++) begin
            cycle(1'b0, 4'h0, 4'h0, 1'b1);
            chk("fib_seq",  32'(if_fib.state), 32'(fib_exp[i]));
            chk("fib_pdone", 32'(if_fib.period_done), 32'(i == 14));
            chk("gal_pdone", 32'(if_gal.period_done), 32'(i == 14));
            if (i < 5) chk("gal_seq", 32'(if_gal.state), 32'(gal_exp[i]));
        end
        chk("fib_period", 32'(if_fib.period_len), 32'd15);
        chk("gal_period", 32'(if_gal.period_len), 32'd15);
        chk("gal_back",   32'(if_gal.state), 32'h1);
        cycle(1'b0, 4'h0, 4'h0, 1'b1);
        chk("pdone_pulse", 32'(if_fib.period_done), 32'h0);

        // 4. Load beats enable; enable low freezes state and count
        cycle(1'b1, 4'h6, 4'h6, 1'b1);
        chk("load_prio_fib", 32'(if_fib.state), 32'h6);
        chk("load_prio_gal", 32'(if_gal.state), 32'h6);
        for (int i = 0; i < 3; i++) cycle(1'b0, 4'h0, 4'h0, 1'b1);
        frozen = m_st[0];
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 4'h0, 4'h0, 1'b0);
            chk("frozen", 32'(if_fib.state), 32'(frozen));
        end
        for (int i = 0; i < 12; i++) cycle(1'b0, 4'h0, 4'h0, 1'b1);
        chk("resume_period", 32'(if_fib.period_len), 32'd15);
        chk("resume_done",   32'(if_fib.period_done), 32'h1);

        // 6. Asynchronous reset mid-run, observed before the next edge
        for (int i = 0; i < 7; i++) cycle(1'b0, 4'h0, 4'h0, 1'b1);
        @(negedge clk);
        #2;
        reset = 1'b0;
        mdl_reset();
        #1;
        chk("arst_state", 32'(if_fib.state), 32'h1);
        chk("arst_len",   32'(if_fib.period_len), 32'h0);
        chk_all();
        @(negedge clk);
        reset = 1'b1;

        // 5. Zero seed
        cycle(1'b1, 4'h0, 4'h0, 1'b0);
`ifdef LFSR_LOCKUP_GUARD_EN
        chk("zero_guard_state",  32'(if_fib.state), 32'h1);
        chk("zero_guard_lockup", 32'(if_fib.lockup), 32'h0);
`else
        chk("zero_state",  32'(if_fib.state), 32'h0);
        chk("zero_lockup", 32'(if_fib.lockup), 32'h1);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 4'h0, 4'h0, 1'b1);
            chk("zero_hold", 32'(if_gal.state), 32'h0);
            chk("zero_done", 32'(if_fib.period_done), 32'h1);
            chk("zero_len",  32'(if_gal.period_len), 32'h1);
        end
`endif

        // Randomised run against the model
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 15) == 0), 4'($urandom), 4'($urandom),
                  ($urandom_range(0, 3) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
